// File: rtl/phys_reg_free_list_pkg.sv
// Shared widths and types for the physical register free list.
// Pointer helpers keep index/wrap-bit handling in one place.
package phys_reg_free_list_pkg;

  localparam int NUM_ARCH_REGS          = 32;
  localparam int NUM_PHYS_REGS          = 64;
  localparam int PHYS_REG_WIDTH         = 6;
  localparam int FREE_LIST_DEPTH        = 64;
  localparam int LOG_FREE_LIST_DEPTH    = 6;
  localparam int CHECKPOINT_COLUMNS     = 4;
  localparam int LOG_CHECKPOINT_COLUMNS = 2;

  typedef logic [PHYS_REG_WIDTH-1:0]         phys_reg_tag_t;
  typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
  typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;
  typedef logic [LOG_FREE_LIST_DEPTH-1:0]    free_list_idx_t;

  function automatic free_list_idx_t ptr_index(input free_list_ptr_t p);
    return p[LOG_FREE_LIST_DEPTH-1:0];
  endfunction

  // Full when the wrap bits differ but the indices coincide.
  function automatic logic ptr_full(input free_list_ptr_t h, input free_list_ptr_t t);
    return (h[LOG_FREE_LIST_DEPTH] != t[LOG_FREE_LIST_DEPTH]) && (ptr_index(h) == ptr_index(t));
  endfunction

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Dispatch/ROB/BRU side of the free list: dequeue, enqueue, checkpoint save/restore, status.
// master = core logic driving requests, slave = the free list.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic                 dequeue_ready;
  phys_reg_tag_t        dequeue_phys_reg_tag;
  logic                 dequeue_valid;
  logic                 enqueue_valid;
  phys_reg_tag_t        enqueue_phys_reg_tag;
  logic                 save_checkpoint_valid;
  checkpoint_column_t   save_checkpoint_column;
  logic                 restore_checkpoint_valid;
  checkpoint_column_t   restore_checkpoint_column;
  free_list_ptr_t       free_count;
  logic                 overflow_error;

  modport master (
    input  dequeue_ready, dequeue_phys_reg_tag, free_count, overflow_error,
    output dequeue_valid, enqueue_valid, enqueue_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_column,
           restore_checkpoint_valid, restore_checkpoint_column
  );

  modport slave (
    output dequeue_ready, dequeue_phys_reg_tag, free_count, overflow_error,
    input  dequeue_valid, enqueue_valid, enqueue_phys_reg_tag,
           save_checkpoint_valid, save_checkpoint_column,
           restore_checkpoint_valid, restore_checkpoint_column
  );

endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with per-checkpoint saved heads for 1-cycle rollback.
// Head tag is read combinationally; enqueues become visible the next cycle; enqueue while full is dropped.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  phys_reg_free_list_if.slave fl
);

  localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  phys_reg_tag_t  entries    [FREE_LIST_DEPTH];
  free_list_ptr_t saved_head [CHECKPOINT_COLUMNS];
  free_list_ptr_t head;
  free_list_ptr_t tail;
  free_list_ptr_t head_next;
  logic           overflow_q;
  logic           empty;
  logic           full;
  logic           deq_fire;
  logic           enq_fire;

  always_comb begin
    empty     = (head == tail);
    full      = ptr_full(head, tail);
    deq_fire  = fl.dequeue_valid && !empty && !fl.restore_checkpoint_valid;
    enq_fire  = fl.enqueue_valid && !full;
    head_next = head;
    if (fl.restore_checkpoint_valid) begin
      head_next = saved_head[fl.restore_checkpoint_column];
    end else if (deq_fire) begin
      head_next = head + free_list_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        entries[i] <= (i < INIT_FREE) ? phys_reg_tag_t'(NUM_ARCH_REGS + i) : '0;
      end
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        saved_head[c] <= '0;
      end
      head       <= '0;
      tail       <= free_list_ptr_t'(INIT_FREE);
      overflow_q <= 1'b0;
    end else begin
      head <= head_next;
      if (enq_fire) begin
        entries[ptr_index(tail)] <= fl.enqueue_phys_reg_tag;
        tail                     <= tail + free_list_ptr_t'(1);
      end else if (fl.enqueue_valid) begin
        overflow_q <= 1'b1;
      end
      // Tail is never rolled back: returned tags are non-speculative.
      if (fl.save_checkpoint_valid && !fl.restore_checkpoint_valid) begin
        saved_head[fl.save_checkpoint_column] <= head_next;
      end
    end
  end

  assign fl.dequeue_ready        = !empty;
  assign fl.dequeue_phys_reg_tag = entries[ptr_index(head)];
  assign fl.free_count           = tail - head;
  assign fl.overflow_error       = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomized + directed bench for phys_reg_free_list; a stream-of-returned-tags model feeds a scoreboard.
// The model treats the list as an ever-growing tag stream with a consumed count that checkpoints rewind.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if fl();

  phys_reg_free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  typedef struct {
    logic rdy;
    int   tag;
    int   cnt;
    logic ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: every tag ever placed in the list, in order; h = tags consumed.
  int   stream[$];
  int   h;
  int   saved[4];
  bit   ovf_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    stream.delete();
    for (int i = 0; i < 32; i++) stream.push_back(32 + i);
    h = 0;
    for (int c = 0; c < 4; c++) saved[c] = 0;
    ovf_m = 1'b0;
  endfunction

  task automatic step(input bit deq, input bit enq, input int etag,
                      input bit sv, input int scol, input bit rs, input int rcol,
                      input bit do_rst = 1'b0);
    int  t;
    int  hn;
    exp_t e;
    fl.dequeue_valid             = deq;
    fl.enqueue_valid             = enq;
    fl.enqueue_phys_reg_tag      = phys_reg_tag_t'(etag);
    fl.save_checkpoint_valid     = sv;
    fl.save_checkpoint_column    = checkpoint_column_t'(scol);
    fl.restore_checkpoint_valid  = rs;
    fl.restore_checkpoint_column = checkpoint_column_t'(rcol);
    rst                          = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_reset();
    end else begin
      t  = stream.size();
      hn = h;
      if (rs) hn = saved[rcol];
      else if (deq && t > h) hn = h + 1;
      if (sv && !rs) saved[scol] = hn;
      if (enq) begin
        if (t - h >= 64) ovf_m = 1'b1;
        else stream.push_back(etag);
      end
      h = hn;
    end
    t     = stream.size();
    e.rdy = (t > h);
    e.tag = (t > h) ? stream[h] : 0;
    e.cnt = t - h;
    e.ovf = ovf_m;
    sbq.push_back(e);
  endtask

  task automatic deq1();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq1(input int tg);
    step(0, 1, tg, 0, 0, 0, 0);
  endtask

  task automatic rst1();
    step(0, 0, 0, 0, 0, 0, 0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("ready", 32'(fl.dequeue_ready), 32'(mon_e.rdy));
      if (mon_e.rdy) chk("tag", 32'(fl.dequeue_phys_reg_tag), mon_e.tag);
      chk("free_count", 32'(fl.free_count), mon_e.cnt);
      chk("overflow", 32'(fl.overflow_error), 32'(mon_e.ovf));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int enq_pct;
    int deq_pct;
    bit d, e, s, r, x;
    int et, sc, rc;

    rst = 1'b1;
    fl.dequeue_valid = 0; fl.enqueue_valid = 0; fl.enqueue_phys_reg_tag = '0;
    fl.save_checkpoint_valid = 0; fl.save_checkpoint_column = '0;
    fl.restore_checkpoint_valid = 0; fl.restore_checkpoint_column = '0;

    // Reset values
    rst1();
    chk("rst_ready", 32'(fl.dequeue_ready), 1);
    chk("rst_tag", 32'(fl.dequeue_phys_reg_tag), 32);
    chk("rst_count", 32'(fl.free_count), 32);
    chk("rst_ovf", 32'(fl.overflow_error), 0);

    // Drain to empty, then dequeue while empty, then enqueue+dequeue while empty
    repeat (32) deq1();
    chk("drain_ready", 32'(fl.dequeue_ready), 0);
    chk("drain_count", 32'(fl.free_count), 0);
    deq1();
    chk("empty_deq_count", 32'(fl.free_count), 0);
    step(1, 1, 5, 0, 0, 0, 0);
    chk("empty_enq_deq_count", 32'(fl.free_count), 1);
    chk("empty_enq_deq_tag", 32'(fl.dequeue_phys_reg_tag), 5);

    // Checkpoint restore drops same-cycle dequeue
    rst1();
    repeat (3) deq1();
    step(0, 0, 0, 1, 1, 0, 0);
    repeat (5) deq1();
    step(1, 0, 0, 0, 0, 1, 1);
    chk("restore_tag", 32'(fl.dequeue_phys_reg_tag), 35);
    chk("restore_count", 32'(fl.free_count), 29);

    // Wrap of the tail index, fill to full, overflow is sticky
    rst1();
    repeat (32) deq1();
    for (int i = 0; i <= 32; i++) enq1(i);
    chk("wrap_count", 32'(fl.free_count), 33);
    repeat (33) deq1();
    for (int i = 0; i < 64; i++) enq1(int'($urandom_range(63)));
    chk("full_count", 32'(fl.free_count), 64);
    chk("full_no_ovf", 32'(fl.overflow_error), 0);
    enq1(63);
    chk("ovf_set", 32'(fl.overflow_error), 1);
    chk("ovf_count", 32'(fl.free_count), 64);
    deq1();
    chk("ovf_sticky", 32'(fl.overflow_error), 1);

    // Restore with same-cycle enqueue; save ignored when restoring
    rst1();
    repeat (4) deq1();
    step(0, 0, 0, 1, 2, 0, 0);
    repeat (3) deq1();
    step(0, 1, 7, 0, 0, 1, 2);
    chk("rs_enq_count", 32'(fl.free_count), 29);
    step(0, 0, 0, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("save_ignored_tag", 32'(fl.dequeue_phys_reg_tag), 32);
    chk("save_ignored_count", 32'(fl.free_count), 33);
    repeat (33) deq1();

    // Reset mid-stream clears pointers and saved heads
    rst1();
    repeat (9) deq1();
    step(1, 0, 0, 1, 3, 0, 0);
    repeat (8) enq1(int'($urandom_range(63)));
    rst1();
    step(0, 0, 0, 0, 0, 1, 3);
    chk("midrst_tag", 32'(fl.dequeue_phys_reg_tag), 32);
    chk("midrst_count", 32'(fl.free_count), 32);
    chk("midrst_ovf", 32'(fl.overflow_error), 0);

    // Random traffic with shifting enqueue/dequeue bias
    enq_pct = 50;
    deq_pct = 50;
    for (int n = 0; n < 2400; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(2))
          0: begin enq_pct = 20; deq_pct = 80; end
          1: begin enq_pct = 50; deq_pct = 50; end
          default: begin enq_pct = 85; deq_pct = 25; end
        endcase
      end
      d  = ($urandom_range(99) < deq_pct);
      e  = ($urandom_range(99) < enq_pct);
      s  = ($urandom_range(99) < 10);
      r  = ($urandom_range(99) < 5);
      x  = ($urandom_range(999) < 3);
      et = int'($urandom_range(63));
      sc = int'($urandom_range(3));
      rc = int'($urandom_range(3));
      // Only rewind to a checkpoint whose tags are still intact in the list.
      if (r && (stream.size() - saved[rc] + (e ? 1 : 0) > 64)) r = 1'b0;
      step(d, e, et, s, sc, r, rc, x);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
